yags_predictor: RTL and testbench

- Fetch-side YAGS direction predictor: choice PHT plus tagged T-cache and NT-cache.
- Produces the IF-stage prediction and carries per-branch metadata through IF/ID and ID/EX, presenting `YAGS_prediction_EX` to the EX-stage resolution logic.
- Consumes the EX-stage resolution (actual outcome, flush) to train its tables and the global history register.

---
 rtl/yags_predictor.sv | 159 +++++++++++++++
 tb/tb_yags_predictor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/yags_predictor.sv
// YAGS direction predictor for the fetch stage.
//   A choice PHT gives a per-PC bias. Two small tagged caches hold the
//   exceptions to that bias: the T-cache for biased-not-taken branches that
//   are taken, and the NT-cache for the reverse. A miss in the probed cache
//   falls back to the bias.
//   Lookup metadata rides IF/ID -> ID/EX so that EX can train the exact
//   entries that produced the prediction.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_IF               fetch PC to predict
//   stall, flush        IF/ID and ID/EX metadata hold / invalidate (flush wins)
//   branch_EX           conditional branch resolving in EX this cycle
//   branch_jump_flag    resolved outcome of that branch (1 = taken)
//   YAGS_prediction_IF  prediction for pc_IF
//   YAGS_prediction_EX  prediction made earlier for the instruction now in EX
//   init_busy           tables are being swept after reset; fetch must stall
module yags_predictor #(
    parameter int PC_W        = 32,
    parameter int CHOICE_BITS = 10,
    parameter int CACHE_BITS  = 8,
    parameter int TAG_W       = 6,
    parameter int GHR_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_IF,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_EX,
    input  logic            branch_jump_flag,
    output logic            YAGS_prediction_IF,
    output logic            YAGS_prediction_EX,
    output logic            init_busy
);
    localparam int CN = 1 << CHOICE_BITS;
    localparam int XN = 1 << CACHE_BITS;

    typedef enum logic {INIT, READY} state_e;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
    } centry_t;

    typedef struct packed {
        logic                   valid;
        logic                   pred;
        logic                   bias;
        logic                   hit;
        logic [CHOICE_BITS-1:0] cidx;
        logic [CACHE_BITS-1:0]  xidx;
        logic [TAG_W-1:0]       tag;
    } meta_t;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [1:0]             choice_q [CN];
    centry_t                tc_q     [XN];
    centry_t                nc_q     [XN];
    state_e                 state_q;
    logic [CHOICE_BITS-1:0] cnt_q;
    logic [GHR_W-1:0]       ghr_q;
    meta_t                  ifid_q, idex_q, look;
    centry_t                probe, uent, cent_d;
    logic [1:0]             choice_d;
    logic                   upd, cwr, chwr, o;

    // PC bits outside index/tag fields carry no prediction information.
    logic unused_pc;
    assign unused_pc = ^{pc_IF[PC_W-1:CACHE_BITS+TAG_W+2], pc_IF[1:0]};

    // ---------------- lookup ----------------
    always_comb begin
        look       = '0;
        look.cidx  = pc_IF[CHOICE_BITS+1:2];
        look.xidx  = pc_IF[CACHE_BITS+1:2] ^ CACHE_BITS'(ghr_q);
        look.tag   = pc_IF[CACHE_BITS+TAG_W+1:CACHE_BITS+2];
        look.bias  = choice_q[look.cidx][1];
        probe      = look.bias ? nc_q[look.xidx] : tc_q[look.xidx];
        look.hit   = probe.vld && (probe.tag == look.tag);
        look.pred  = look.hit ? probe.ctr[1] : look.bias;
        look.valid = (state_q == READY);
    end

    assign YAGS_prediction_IF = (state_q == READY) && look.pred;
    assign YAGS_prediction_EX = (state_q == READY) && idex_q.valid && idex_q.pred;
    assign init_busy          = rst || (state_q == INIT);

    // ---------------- update ----------------
    assign o   = branch_jump_flag;
    assign upd = !rst && (state_q == READY) && branch_EX && idex_q.valid;

    always_comb begin
        uent     = idex_q.bias ? nc_q[idex_q.xidx] : tc_q[idex_q.xidx];
        cent_d   = uent;
        cwr      = 1'b0;
        if (idex_q.hit) begin
            cent_d.ctr = sat2(uent.ctr, o);
            cwr        = 1'b1;
        end else if (o != idex_q.bias) begin
            // new exception entry starts weakly agreeing with the outcome
            cent_d = '{vld: 1'b1, tag: idex_q.tag,
                       ctr: idex_q.bias ? 2'b01 : 2'b10};
            cwr    = 1'b1;
        end
        // keep the bias when the cache already corrected it
        chwr     = !(idex_q.hit && (idex_q.pred == o) && (idex_q.bias != o));
        choice_d = sat2(choice_q[idex_q.cidx], o);
    end

    // Table storage: swept during INIT, trained in READY. Reads elsewhere
    // see pre-edge values, so a same-cycle lookup gets the old entry.
    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT) begin
            choice_q[cnt_q] <= 2'b01;
            if (32'(cnt_q) < XN) begin
                tc_q[cnt_q[CACHE_BITS-1:0]].vld <= 1'b0;
                nc_q[cnt_q[CACHE_BITS-1:0]].vld <= 1'b0;
            end
        end else if (upd) begin
            if (chwr) choice_q[idex_q.cidx] <= choice_d;
            if (cwr) begin
                if (idex_q.bias) nc_q[idex_q.xidx] <= cent_d;
                else             tc_q[idex_q.xidx] <= cent_d;
            end
        end
    end

    // ---------------- control, history, metadata pipe ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ghr_q   <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) state_q <= READY;
                end
                READY: if (upd) ghr_q <= {ghr_q[GHR_W-2:0], o};
                default: state_q <= INIT;
            endcase
            if (flush) begin
                ifid_q.valid <= 1'b0;
                idex_q.valid <= 1'b0;
            end else if (!stall) begin
                ifid_q <= look;
                idex_q <= ifid_q;
            end
        end
    end
endmodule

// File: tb/tb_yags_predictor.sv
// Directed bench for yags_predictor. Each branch is fetched once, carried
// two cycles to EX with filler fetches of PC 0 behind it, then resolved.
// Expected predictions are derived by hand from the table/GHR state that
// the preceding steps leave behind (noted per step).
module tb_yags_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_IF = 32'h100;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_EX = 1'b0;
    logic        branch_jump_flag = 1'b0;
    logic        YAGS_prediction_IF;
    logic        YAGS_prediction_EX;
    logic        init_busy;

    int total  = 0;
    int passed = 0;
    int n;

    yags_predictor dut (
        .clk                (clk),
        .rst                (rst),
        .pc_IF              (pc_IF),
        .stall              (stall),
        .flush              (flush),
        .branch_EX          (branch_EX),
        .branch_jump_flag   (branch_jump_flag),
        .YAGS_prediction_IF (YAGS_prediction_IF),
        .YAGS_prediction_EX (YAGS_prediction_EX),
        .init_busy          (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // fetch pc, check IF prediction, carry to EX, check EX prediction, resolve
    task automatic run_br(input logic [31:0] pc, input logic out, input logic exp, input string tag);
        @(negedge clk); pc_IF = pc; branch_EX = 1'b0; #1;
        chk({tag, "_if"}, {31'b0, YAGS_prediction_IF}, {31'b0, exp});
        @(negedge clk); pc_IF = 32'h0;
        @(negedge clk);
        chk({tag, "_ex"}, {31'b0, YAGS_prediction_EX}, {31'b0, exp});
        branch_EX = 1'b1; branch_jump_flag = out;
        @(negedge clk); branch_EX = 1'b0;
    endtask

    // release reset and count cycles with init_busy high (bounded)
    task automatic count_init(input string tag);
        rst = 1'b0; #1;
        chk({tag, "_if_init"}, {31'b0, YAGS_prediction_IF}, 32'h0);
        chk({tag, "_ex_init"}, {31'b0, YAGS_prediction_EX}, 32'h0);
        n = 0;
        while (init_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_init_cycles"}, n, 1024);
    endtask

    initial begin
        // ---- power-on reset ----
        repeat (3) @(negedge clk);
        chk("busy_in_rst", {31'b0, init_busy}, 32'h1);
        count_init("por");

        // ---- training 0x100 always taken (cidx 0x40, tag 0) ----
        run_br(32'h100, 1'b1, 1'b0, "tr1");  // ghr 00, choice 01, T miss; alloc T[40]; choice 10
        run_br(32'h100, 1'b1, 1'b1, "tr2");  // ghr 01, bias 1, NT[41] miss -> 1; choice 11
        run_br(32'h100, 1'b1, 1'b1, "tr3");  // ghr 03, NT[43] miss -> 1; ghr -> 07

        // ---- exception allocation ----
        run_br(32'h100, 1'b0, 1'b1, "exc_alloc"); // NT[47] miss -> 1; alloc ctr 01; choice 10; ghr 0E
        // fillers at 0x800 (cidx 0x200, tag 2) steer ghr back to 07
        run_br(32'h800, 1'b0, 1'b0, "f1");   // xidx 0E
        run_br(32'h800, 1'b0, 1'b0, "f2");   // xidx 1C
        run_br(32'h800, 1'b0, 1'b0, "f3");   // xidx 38
        run_br(32'h800, 1'b0, 1'b0, "f4");   // xidx 70
        run_br(32'h800, 1'b0, 1'b0, "f5");   // xidx E0
        run_br(32'h800, 1'b1, 1'b0, "f6");   // alloc T[C0], choice 01
        run_br(32'h800, 1'b1, 1'b0, "f7");   // alloc T[81], choice 10
        run_br(32'h800, 1'b1, 1'b1, "f8");   // bias 1, NT[03] miss; ghr 07
        run_br(32'h100, 1'b0, 1'b0, "exc_hit"); // NT[47] hit ctr 01 -> 0; choice held 10; ghr 0E

        // ---- tag aliasing on T[1C]: tag 4 vs tag 9 ----
        run_br(32'h1000, 1'b0, 1'b0, "al_a0");     // xidx 0E miss; choice[0] 00; ghr 1C
        run_br(32'h1000, 1'b1, 1'b0, "al_a1");     // xidx 1C miss; alloc tag4 ctr10; ghr 39
        run_br(32'h1094, 1'b1, 1'b1, "al_a_hit");  // 25^39=1C tag4 hit -> 1; ghr 73
        run_br(32'h25BC, 1'b1, 1'b0, "al_b_miss"); // 6F^73=1C tag9 miss -> 0; alloc tag9; ghr E7
        run_br(32'h13EC, 1'b0, 1'b0, "al_a_miss"); // FB^E7=1C tag4 now misses; ghr CE
        run_br(32'h2748, 1'b1, 1'b1, "al_b_hit");  // D2^CE=1C tag9 hit -> 1; ghr 9D

        // ---- stall / flush (0x100: bias 1, NT[DD] miss -> 1; PC 0 -> 0) ----
        @(negedge clk); pc_IF = 32'h100; #1;
        chk("stl_if", {31'b0, YAGS_prediction_IF}, 32'h1);
        @(negedge clk); pc_IF = 32'h0;
        @(negedge clk);
        chk("stl_ex0", {31'b0, YAGS_prediction_EX}, 32'h1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_hold", {31'b0, YAGS_prediction_EX}, 32'h1);
        end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; stall = 1'b0;
        chk("flush_ex", {31'b0, YAGS_prediction_EX}, 32'h0);
        branch_EX = 1'b1; branch_jump_flag = 1'b0;  // EX slot invalid: must be ignored
        @(negedge clk); branch_EX = 1'b0;
        chk("flush_ex2", {31'b0, YAGS_prediction_EX}, 32'h0);
        run_br(32'h100, 1'b1, 1'b1, "post_flush");  // still ghr 9D, choice 10 -> 1

        // ---- reset mid-run ----
        @(negedge clk); rst = 1'b1; pc_IF = 32'h100;
        repeat (2) @(negedge clk);
        chk("busy_in_rst2", {31'b0, init_busy}, 32'h1);
        count_init("mid");
        run_br(32'h100, 1'b1, 1'b0, "rst_tr1");  // ghr 00, T[40] cleared -> 0; alloc T[40]; ghr 01
        run_br(32'h104, 1'b1, 1'b1, "rst_ghr");  // 41^01=40 tag0 hit ctr10 -> 1

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
